// File: rtl/tm1638_display_scheduler.sv
// tm1638_display_scheduler
//   Sequences a tm1638_led_key driver. A 16-byte shadow (8 seg7 digits at 0-7 and 8 LEDs at 8-15)
//   is pushed to the driver one dirty entry per transfer. The buttons are polled on a fixed period,
//   and the power-up commands (address mode, display control) are issued automatically. This block
//   is the only source of the driver's enable pulses.
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_wr_en/addr/data     shadow write port (addr 0-7 seg7, 8-15 LED)
//   i_brightness          display brightness 0-7
//   i_display_on          1 = display on
//   i_drv_idle            driver idle flag
//   i_drv_btn_state       driver button bits
//   o_cmd_en/o_seg7_en/o_led_en/o_btn_en
//                         one-cycle driver enables, at most one per cycle
//   o_idx, o_data         driver index/data, valid with the enable
//   o_wait_counter        strobe-high hold, constant STB_HOLD
//   o_btn_state           last polled buttons
//   o_btn_changed         one-cycle pulse when o_btn_state changes
//   o_busy                init pending, work queued, or a transfer in flight
module tm1638_display_scheduler #(
    parameter int unsigned CLOCK_FREQ_MHz = 12,
    parameter int unsigned POLL_PERIOD_US = 10000,
    parameter int unsigned STB_HOLD       = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_addr,
    input  logic [7:0]  i_wr_data,
    input  logic [2:0]  i_brightness,
    input  logic        i_display_on,
    input  logic        i_drv_idle,
    input  logic [7:0]  i_drv_btn_state,
    output logic        o_cmd_en,
    output logic        o_seg7_en,
    output logic        o_led_en,
    output logic        o_btn_en,
    output logic [2:0]  o_idx,
    output logic [7:0]  o_data,
    output logic [27:0] o_wait_counter,
    output logic [7:0]  o_btn_state,
    output logic        o_btn_changed,
    output logic        o_busy
);

    localparam int unsigned PollCycles = CLOCK_FREQ_MHz * POLL_PERIOD_US;
    localparam int unsigned PollW      = (PollCycles > 1) ? $clog2(PollCycles) : 1;

    typedef enum logic [1:0] {StWaitIdle, StSelect, StIssue, StBusy} state_e;
    typedef enum logic [1:0] {JobCmd, JobSeg7, JobLed, JobBtn} job_e;

    state_e             state_q, state_d;
    job_e               job_q, job_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               busy_first_q, busy_first_d;
    logic [7:0]         shadow_q [16];
    logic [15:0]        dirty_q, dirty_d;
    logic               disp_dirty_q, disp_dirty_d;
    logic               init_pending_q, init_pending_d;
    logic               poll_due_q, poll_due_d;
    logic [PollW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [3:0]         rr_q, rr_d;
    logic [2:0]         bright_q;
    logic               on_q;
    logic [7:0]         btn_state_q, btn_state_d;
    logic               btn_changed_q, btn_changed_d;

    logic               pick_found;
    logic [3:0]         pick_addr;
    logic               poll_tc;
    logic               disp_change;

    // First dirty entry at or after the round-robin pointer, wrapping 15 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_addr  = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (!pick_found && dirty_q[rr_q + 4'(k)]) begin
                pick_found = 1'b1;
                pick_addr  = rr_q + 4'(k);
            end
        end
    end

    assign poll_tc     = (poll_cnt_q == PollW'(PollCycles - 1));
    assign disp_change = (i_brightness != bright_q) || (i_display_on != on_q);

    always_comb begin
        state_d        = state_q;
        job_d          = job_q;
        idx_d          = idx_q;
        data_d         = data_q;
        busy_first_d   = busy_first_q;
        dirty_d        = dirty_q;
        disp_dirty_d   = disp_dirty_q;
        init_pending_d = init_pending_q;
        poll_due_d     = poll_due_q;
        rr_d           = rr_q;
        btn_state_d    = btn_state_q;
        btn_changed_d  = 1'b0;
        poll_cnt_d     = poll_tc ? '0 : poll_cnt_q + PollW'(1);

        unique case (state_q)
            StWaitIdle: begin
                if (i_drv_idle) state_d = StSelect;
            end
            StSelect: begin
                if (init_pending_q) begin
                    job_d          = JobCmd;
                    idx_d          = 3'd0;
                    data_d         = 8'h44;
                    init_pending_d = 1'b0;
                    state_d        = StIssue;
                end else if (disp_dirty_q) begin
                    job_d        = JobCmd;
                    idx_d        = 3'd0;
                    data_d       = on_q ? {5'b10001, bright_q} : 8'h80;
                    disp_dirty_d = 1'b0;
                    state_d      = StIssue;
                end else if (poll_due_q) begin
                    job_d      = JobBtn;
                    idx_d      = 3'd0;
                    data_d     = 8'h00;
                    poll_due_d = 1'b0;
                    state_d    = StIssue;
                end else if (pick_found) begin
                    job_d              = pick_addr[3] ? JobLed : JobSeg7;
                    idx_d              = pick_addr[2:0];
                    data_d             = shadow_q[pick_addr];
                    dirty_d[pick_addr] = 1'b0;
                    rr_d               = pick_addr + 4'd1;
                    state_d            = StIssue;
                end
            end
            StIssue: begin
                busy_first_d = 1'b1;
                state_d      = StBusy;
            end
            StBusy: begin
                busy_first_d = 1'b0;
                // The driver may still show idle in the cycle right after the pulse.
                if (!busy_first_q && i_drv_idle) begin
                    state_d = StSelect;
                    if (job_q == JobBtn) begin
                        btn_state_d   = i_drv_btn_state;
                        btn_changed_d = (i_drv_btn_state != btn_state_q);
                    end
                end
            end
            default: state_d = StWaitIdle;
        endcase

        // New requests in the same cycle override the clear above.
        if (disp_change) disp_dirty_d = 1'b1;
        if (poll_tc) poll_due_d = 1'b1;
        if (i_wr_en) dirty_d[i_wr_addr] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= StWaitIdle;
            job_q          <= JobCmd;
            idx_q          <= 3'd0;
            data_q         <= 8'h00;
            busy_first_q   <= 1'b0;
            for (int i = 0; i < 16; i++) shadow_q[i] <= 8'h00;
            dirty_q        <= 16'hFFFF;
            disp_dirty_q   <= 1'b1;
            init_pending_q <= 1'b1;
            poll_due_q     <= 1'b0;
            poll_cnt_q     <= '0;
            rr_q           <= 4'd0;
            bright_q       <= 3'd0;
            on_q           <= 1'b0;
            btn_state_q    <= 8'h00;
            btn_changed_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            job_q          <= job_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            busy_first_q   <= busy_first_d;
            if (i_wr_en) shadow_q[i_wr_addr] <= i_wr_data;
            dirty_q        <= dirty_d;
            disp_dirty_q   <= disp_dirty_d;
            init_pending_q <= init_pending_d;
            poll_due_q     <= poll_due_d;
            poll_cnt_q     <= poll_cnt_d;
            rr_q           <= rr_d;
            bright_q       <= i_brightness;
            on_q           <= i_display_on;
            btn_state_q    <= btn_state_d;
            btn_changed_q  <= btn_changed_d;
        end
    end

    assign o_cmd_en       = (state_q == StIssue) && (job_q == JobCmd);
    assign o_seg7_en      = (state_q == StIssue) && (job_q == JobSeg7);
    assign o_led_en       = (state_q == StIssue) && (job_q == JobLed);
    assign o_btn_en       = (state_q == StIssue) && (job_q == JobBtn);
    assign o_idx          = idx_q;
    assign o_data         = data_q;
    assign o_wait_counter = 28'(STB_HOLD);
    assign o_btn_state    = btn_state_q;
    assign o_btn_changed  = btn_changed_q;
    assign o_busy         = init_pending_q || disp_dirty_q || (|dirty_q) ||
                            (state_q == StIssue) || (state_q == StBusy);

endmodule

// File: tb/tb_tm1638_display_scheduler.sv
module tb_tm1638_display_scheduler;

    localparam int unsigned Freq       = 1;
    localparam int unsigned Period     = 400;
    localparam int unsigned PollCycles = Freq * Period;
    localparam int unsigned StbHold    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  bright;
    logic        disp_on;
    logic        drv_idle = 1'b1;
    logic [7:0]  drv_btn;
    logic        cmd_en, seg7_en, led_en, btn_en;
    logic [2:0]  idx;
    logic [7:0]  data;
    logic [27:0] wait_counter;
    logic [7:0]  btn_state;
    logic        btn_changed;
    logic        busy;

    tm1638_display_scheduler #(
        .CLOCK_FREQ_MHz(Freq),
        .POLL_PERIOD_US(Period),
        .STB_HOLD(StbHold)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_wr_en(wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_brightness(bright),
        .i_display_on(disp_on),
        .i_drv_idle(drv_idle),
        .i_drv_btn_state(drv_btn),
        .o_cmd_en(cmd_en),
        .o_seg7_en(seg7_en),
        .o_led_en(led_en),
        .o_btn_en(btn_en),
        .o_idx(idx),
        .o_data(data),
        .o_wait_counter(wait_counter),
        .o_btn_state(btn_state),
        .o_btn_changed(btn_changed),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 0 cmd, 1 seg7, 2 led, 3 button poll
    typedef struct {
        int kind;
        int idx;
        int data;
        int cyc;
    } xfer_t;

    xfer_t      log_q[$];
    xfer_t      exp_q[$];
    logic [7:0] panel [16];
    logic [7:0] mdl [16];
    logic [7:0] last_cmd;
    int         changed_pulses;
    logic [7:0] changed_val;
    int         drv_cnt = 0;
    bit         stall = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] disp_cmd(input logic [2:0] b, input logic on);
        return on ? (8'h88 | {5'b0, b}) : 8'h80;
    endfunction

    // Transfer monitor plus a driver model that goes busy for a random time after each enable.
    always @(negedge clk) begin
        xfer_t t;
        int    n;
        n = int'(cmd_en) + int'(seg7_en) + int'(led_en) + int'(btn_en);
        if (n > 1) check("onehot_enable", n, 1);
        t.cyc  = cyc;
        t.idx  = 0;
        t.data = int'(data);
        t.kind = -1;
        if (cmd_en) begin
            t.kind   = 0;
            last_cmd = data;
        end else if (seg7_en) begin
            t.kind = 1;
            t.idx  = int'(idx);
            panel[idx] = data;
        end else if (led_en) begin
            t.kind = 2;
            t.idx  = int'(idx);
            panel[{1'b1, idx}] = data;
        end else if (btn_en) begin
            t.kind = 3;
            t.data = 0;
        end
        if (t.kind >= 0) log_q.push_back(t);
        if (btn_changed) begin
            changed_pulses++;
            changed_val = btn_state;
        end
        if (n > 0) begin
            drv_cnt  = $urandom_range(1, 5);
            drv_idle = 1'b0;
        end else begin
            if (drv_cnt > 0) drv_cnt--;
            drv_idle = (drv_cnt == 0) && !stall;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        mdl[a]  = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_quiet"}, busy, 0);
    endtask

    task automatic make_init(input logic [7:0] cmd2);
        xfer_t t;
        exp_q.delete();
        t.cyc = 0;
        t = '{0, 0, 8'h44, 0}; exp_q.push_back(t);
        t = '{0, 0, int'(cmd2), 0}; exp_q.push_back(t);
        for (int i = 0; i < 8; i++) begin t = '{1, i, 0, 0}; exp_q.push_back(t); end
        for (int i = 0; i < 8; i++) begin t = '{2, i, 0, 0}; exp_q.push_back(t); end
    endtask

    // Compares the non-poll transfers logged since 'start' against exp_q.
    task automatic check_seq(input string tag, input int start);
        xfer_t got[$];
        for (int i = start; i < log_q.size(); i++)
            if (log_q[i].kind != 3) got.push_back(log_q[i]);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", tag, i),
                  (got[i].kind << 16) | (got[i].idx << 8) | got[i].data,
                  (exp_q[i].kind << 16) | (exp_q[i].idx << 8) | exp_q[i].data);
    endtask

    function automatic int count_btn();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].kind == 3) n++;
        return n;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n, nb, cnt, first_cmd, seen_cmd, b0, b1;
        xfer_t t;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_data = 8'd0;
        bright  = 3'd7;
        disp_on = 1'b1;
        drv_btn = 8'h00;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        tick(3);

        // Reset state
        check("rst_enables", {cmd_en, seg7_en, led_en, btn_en}, 0);
        check("rst_idx", idx, 0);
        check("rst_data", data, 0);
        check("rst_btn_state", btn_state, 0);
        check("rst_btn_changed", btn_changed, 0);
        check("rst_busy", busy, 1);
        check("wait_counter", wait_counter, StbHold);

        // Power-up sequence
        start = log_q.size();
        rst_n = 1'b1;
        wait_quiet("init", 3000);
        make_init(8'h8F);
        check_seq("init", start);

        // Two single writes
        start = log_q.size();
        write(4'd3, 8'h4F);
        write(4'd11, 8'h01);
        wait_quiet("wr", 1000);
        exp_q.delete();
        t = '{1, 3, 8'h4F, 0}; exp_q.push_back(t);
        t = '{2, 3, 8'h01, 0}; exp_q.push_back(t);
        check_seq("wr", start);

        // Display off while entries are queued: the off command overtakes them
        start = log_q.size();
        for (int a = 0; a < 6; a++) write(4'(a), 8'(8'h10 + a));
        disp_on = 1'b0;
        n = cyc;
        tick(1);
        wait_quiet("off", 1000);
        cnt = 0;
        seen_cmd = 0;
        first_cmd = 0;
        for (int i = start; i < log_q.size(); i++) begin
            if (log_q[i].cyc > n && !seen_cmd) begin
                if (log_q[i].kind == 0) begin
                    seen_cmd  = 1;
                    first_cmd = log_q[i].data;
                end else if (log_q[i].kind != 3) begin
                    cnt++;
                end
            end
        end
        check("off_cmd_seen", seen_cmd, 1);
        check("off_cmd_value", first_cmd, 8'h80);
        check("off_entries_before_cmd_le1", int'(cnt <= 1), 1);
        disp_on = 1'b1;
        tick(1);
        wait_quiet("on", 1000);
        check("on_cmd_value", last_cmd, disp_cmd(3'd7, 1'b1));

        // Rewrite addr 5 in the cycle its transfer is issued
        start = log_q.size();
        write(4'd5, 8'hA1);
        n = 0;
        while (!(seg7_en && idx == 3'd5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rewrite_issue_seen", int'(seg7_en && idx == 3'd5), 1);
        write(4'd5, 8'h5B);
        wait_quiet("rewrite", 1000);
        exp_q.delete();
        t = '{1, 5, 8'hA1, 0}; exp_q.push_back(t);
        t = '{1, 5, 8'h5B, 0}; exp_q.push_back(t);
        check_seq("rewrite", start);

        // Button polling
        drv_btn = 8'h05;
        changed_pulses = 0;
        n = 0;
        while (btn_state !== 8'h05 && n < 3 * PollCycles) begin
            @(negedge clk);
            n++;
        end
        check("poll_state", btn_state, 8'h05);
        tick(2);
        check("poll_pulses", changed_pulses, 1);
        check("poll_pulse_value", changed_val, 8'h05);
        nb = count_btn();
        n = 0;
        while (count_btn() < nb + 2 && n < 3 * PollCycles) begin
            @(negedge clk);
            n++;
        end
        check("poll_repeat_seen", int'(count_btn() >= nb + 2), 1);
        tick(10);
        check("poll_repeat_no_pulse", changed_pulses, 1);
        b0 = -1;
        b1 = -1;
        foreach (log_q[i]) if (log_q[i].kind == 3) begin b0 = b1; b1 = log_q[i].cyc; end
        check("poll_spacing", b1 - b0, PollCycles);

        // Randomized writes and display settings; panel must converge to the shadow
        drv_btn = 8'h0A;
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 9);
            if (n < 7) write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            else if (n == 7) bright = 3'($urandom_range(0, 7));
            else disp_on = 1'($urandom_range(0, 1));
            tick($urandom_range(0, 3));
        end
        tick(1);
        wait_quiet("rand", 4000);
        for (int a = 0; a < 16; a++) check($sformatf("rand_panel_%0d", a), panel[a], mdl[a]);
        check("rand_disp_cmd", last_cmd, disp_cmd(bright, disp_on));

        // Reset while the driver is busy, release before it goes idle
        write(4'd2, 8'h77);
        n = 0;
        while (drv_idle !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        stall = 1'b1;
        rst_n = 1'b0;
        tick(1);
        check("mrst_enables", {cmd_en, seg7_en, led_en, btn_en}, 0);
        check("mrst_busy", busy, 1);
        check("mrst_data", data, 0);
        check("mrst_btn_state", btn_state, 0);
        tick(2);
        rst_n = 1'b1;
        start = log_q.size();
        tick(20);
        check("mrst_no_pulse_while_drv_busy", log_q.size() - start, 0);
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        stall = 1'b0;
        wait_quiet("mrst", 3000);
        make_init(disp_cmd(bright, disp_on));
        check_seq("mrst_init", start);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
